// File: rtl/dmtd_phase_meter.sv
// Multi-channel DMTD phase meter: synchronised beats, per-channel ref->ch distance, round-robin result stream.
// Optional input deglitch filter is built when DMTD_DEGLITCH_EN is defined.
`timescale 1ns/1ps
module dmtd_phase_meter #(
  parameter int SYNC_DEPTH   = 3,
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int DEGLITCH_LEN = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              ref_clk_async,
  input  logic [NUM_CH-1:0] ch_clk_async,
  output logic [NUM_CH-1:0] xor_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [CNT_W-1:0]  out_phase,
  output logic [CNT_W-1:0]  ref_period,
  output logic [NUM_CH-1:0] overrun
);

  localparam int NIN = NUM_CH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W+1)'(NUM_CH);

  typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} state_t;

  if (SYNC_DEPTH < 2 || NUM_CH < 1 || NUM_CH > 16 || DEGLITCH_LEN < 1) begin : g_param_check
    $error("dmtd_phase_meter: illegal parameter set");
  end

  // Bit 0 of every input vector is the reference beat, bits 1.. the channels.
  logic [NIN-1:0] sync_r [SYNC_DEPTH];
  logic [NIN-1:0] filt_s;
  logic [NIN-1:0] filt_nxt_s;
  logic [NIN-1:0] prev_r;
  logic [NIN-1:0] rise_s;
  logic [NUM_CH-1:0] xor_r;

  // Input synchroniser chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_DEPTH; s++) sync_r[s] <= {NIN{1'b0}};
    end else begin
      sync_r[0] <= {ch_clk_async, ref_clk_async};
      for (int s = 1; s < SYNC_DEPTH; s++) sync_r[s] <= sync_r[s-1];
    end
  end

`ifdef DMTD_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH_LEN + 1);
  logic [NIN-1:0]  filt_r;
  logic [DG_W-1:0] dg_cnt_r     [NIN];
  logic [DG_W-1:0] dg_cnt_nxt_s [NIN];

  // Accept a new level only after DEGLITCH_LEN consecutive samples disagree with the filtered one
  always_comb begin
    filt_nxt_s = filt_r;
    for (int k = 0; k < NIN; k++) begin
      dg_cnt_nxt_s[k] = {DG_W{1'b0}};
      if (sync_r[SYNC_DEPTH-1][k] != filt_r[k]) begin
        if (dg_cnt_r[k] == DG_W'(DEGLITCH_LEN - 1)) begin
          filt_nxt_s[k] = sync_r[SYNC_DEPTH-1][k];
        end else begin
          dg_cnt_nxt_s[k] = dg_cnt_r[k] + DG_W'(1);
        end
      end else begin
        dg_cnt_nxt_s[k] = {DG_W{1'b0}};
      end
    end
  end

  // Deglitch filter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= {NIN{1'b0}};
      for (int k = 0; k < NIN; k++) dg_cnt_r[k] <= {DG_W{1'b0}};
    end else begin
      filt_r <= filt_nxt_s;
      for (int k = 0; k < NIN; k++) dg_cnt_r[k] <= dg_cnt_nxt_s[k];
    end
  end

  assign filt_s = filt_r;
`else
  assign filt_s     = sync_r[SYNC_DEPTH-1];
  assign filt_nxt_s = sync_r[SYNC_DEPTH-2];
`endif

  // Edge register; xor_out is registered from next-cycle filtered levels so it tracks filt_s exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= {NIN{1'b0}};
      xor_r  <= {NUM_CH{1'b0}};
    end else begin
      prev_r <= filt_s;
      xor_r  <= filt_nxt_s[NIN-1:1] ^ {NUM_CH{filt_nxt_s[0]}};
    end
  end

  assign rise_s = filt_s & ~prev_r;

  logic              ref_rise_s;
  logic [NUM_CH-1:0] ch_rise_s;
  assign ref_rise_s = enable & rise_s[0];
  assign ch_rise_s  = rise_s[NIN-1:1] & {NUM_CH{enable}};

  // Every ref strobe restarts all channels, so one counter serves phase and period alike.
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             ref_seen_r;

  // Saturating distance counter and reference period capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      period_r   <= {CNT_W{1'b0}};
      ref_seen_r <= 1'b0;
    end else if (!enable) begin
      cnt_r      <= {CNT_W{1'b0}};
      ref_seen_r <= 1'b0;
    end else if (ref_rise_s) begin
      cnt_r      <= CNT_W'(1);
      ref_seen_r <= 1'b1;
      if (ref_seen_r) period_r <= cnt_r;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  state_t            state_r     [NUM_CH];
  state_t            state_nxt_s [NUM_CH];
  logic [NUM_CH-1:0] cap_s;
  logic [CNT_W-1:0]  cap_val_s   [NUM_CH];

  // Per-channel IDLE/ARMED next state and capture decision
  always_comb begin
    cap_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt_s[i] = state_r[i];
      cap_val_s[i]   = cnt_r;
      if (!enable) begin
        state_nxt_s[i] = ST_IDLE;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (ref_rise_s && ch_rise_s[i]) begin
              cap_s[i]     = 1'b1;
              cap_val_s[i] = {CNT_W{1'b0}};
            end else if (ref_rise_s) begin
              state_nxt_s[i] = ST_ARMED;
            end else begin
              state_nxt_s[i] = ST_IDLE;
            end
          end
          ST_ARMED: begin
            if (ch_rise_s[i]) begin
              cap_s[i]       = 1'b1;
              state_nxt_s[i] = ref_rise_s ? ST_ARMED : ST_IDLE;
            end else begin
              state_nxt_s[i] = ST_ARMED;
            end
          end
          default: state_nxt_s[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) state_r[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state_r[i] <= state_nxt_s[i];
    end
  end

  logic [NUM_CH-1:0] pend_r;
  logic [NUM_CH-1:0] ovr_r;
  logic [CNT_W-1:0]  pend_val_r [NUM_CH];
  logic [NUM_CH-1:0] avail_s;
  logic [CH_W-1:0]   last_r;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [CH_W:0]     pos_s;
  logic              gnt_any_s;
  logic              load_s;
  logic              gnt_s;
  logic              out_valid_r;
  logic [CH_W-1:0]   out_ch_r;
  logic [CNT_W-1:0]  out_phase_r;

  assign avail_s = pend_r & {NUM_CH{enable}};
  assign load_s  = ~out_valid_r | out_ready;
  assign gnt_s   = gnt_any_s & load_s;

  // Round robin: first available channel after the last granted one
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = last_r;
    pos_s     = {(CH_W+1){1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      pos_s = {1'b0, last_r} + (CH_W+1)'(k + 1);
      if (pos_s >= NUM_CH_V) begin
        pos_s = pos_s - NUM_CH_V;
      end else begin
        pos_s = pos_s;
      end
      if (!gnt_any_s && avail_s[pos_s[CH_W-1:0]]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = pos_s[CH_W-1:0];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // Pending buffer; a capture racing a grant of the same channel keeps the new value without overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_CH{1'b0}};
      ovr_r  <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) pend_val_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable) begin
          pend_r[i] <= 1'b0;
          ovr_r[i]  <= 1'b0;
        end else if (cap_s[i]) begin
          pend_r[i]     <= 1'b1;
          pend_val_r[i] <= cap_val_s[i];
          if (pend_r[i] && !(gnt_s && gnt_idx_s == CH_W'(i))) ovr_r[i] <= 1'b1;
        end else if (gnt_s && gnt_idx_s == CH_W'(i)) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: reloads when empty or when the current beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= {CH_W{1'b0}};
      out_phase_r <= {CNT_W{1'b0}};
      last_r      <= CH_W'(NUM_CH - 1);
    end else if (load_s) begin
      if (gnt_any_s) begin
        out_valid_r <= 1'b1;
        out_ch_r    <= gnt_idx_s;
        out_phase_r <= pend_val_r[gnt_idx_s];
        last_r      <= gnt_idx_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign xor_out    = xor_r;
  assign out_valid  = out_valid_r;
  assign out_ch     = out_ch_r;
  assign out_phase  = out_phase_r;
  assign ref_period = period_r;
  assign overrun    = ovr_r;

endmodule

// File: tb/tb_dmtd_phase_meter.sv
// Scoreboard bench for dmtd_phase_meter: an event-level model predicts each result from input edge times.
`timescale 1ns/1ps
module tb_dmtd_phase_meter;
  localparam int SD  = 3;
  localparam int NC  = 4;
  localparam int CW  = 10;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          ref_clk_async = 1'b0;
  logic [NC-1:0] ch_clk_async = '0;
  logic [NC-1:0] xor_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_ch;
  logic [CW-1:0] out_phase;
  logic [CW-1:0] ref_period;
  logic [NC-1:0] overrun;

  dmtd_phase_meter #(.SYNC_DEPTH(SD), .NUM_CH(NC), .CNT_W(CW), .DEGLITCH_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ref_clk_async(ref_clk_async),
    .ch_clk_async(ch_clk_async), .xor_out(xor_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_phase(out_phase),
    .ref_period(ref_period), .overrun(overrun));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed { logic [1:0] ch; logic [CW-1:0] ph; } exp_t;
  exp_t exp_q[$];
  int   ord_q[$];
  bit   sb_on = 1'b1;
  bit   rdy_rand = 1'b0;
  bit   rdy_fix = 1'b0;

  // Event-level reference model state
  int          cyc = 0;
  int          last_ref = 0;
  logic [NC-1:0] armed = '0;
  bit          ref_seen = 1'b0;
  int          m_period = 0;
  int          m_last [NC];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int d);
    return (d > SAT) ? SAT : d;
  endfunction

  // One clock cycle: drive new input levels and predict results from rising edges
  task automatic step(input logic r, input logic [NC-1:0] c);
    logic          rr;
    logic [NC-1:0] rc;
    int            v;
    @(posedge clk);
    #2;
    cyc++;
    rr = r & ~ref_clk_async;
    rc = c & ~ch_clk_async;
    if (enable) begin
      for (int i = 0; i < NC; i++) begin
        if (rc[i]) begin
          if (armed[i]) v = sat(cyc - last_ref);
          else if (rr) v = 0;
          else v = -1;
          if (v >= 0) begin
            m_last[i] = v;
            if (sb_on) exp_q.push_back('{ch: 2'(i), ph: CW'(v)});
          end
        end
      end
      armed = rr ? (armed | ~rc) : (armed & ~rc);
      if (rr) begin
        if (ref_seen) m_period = sat(cyc - last_ref);
        last_ref = cyc;
        ref_seen = 1'b1;
      end
    end else begin
      armed = '0;
      ref_seen = 1'b0;
    end
    ref_clk_async = r;
    ch_clk_async  = c;
    out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_fix;
  endtask

  task automatic set_en(input logic v);
    repeat (SD + 4) step(1'b0, '0);
    enable = v;
    repeat (SD + 4) step(1'b0, '0);
  endtask

  // Monitor: pop and compare on every handshake, and check that a stalled beat holds
  bit          hold_v = 1'b0;
  logic [1:0]  hold_ch;
  logic [CW-1:0] hold_ph;
  always @(negedge clk) begin
    int idx;
    idx = -1;
    if (rst_n) begin
      if (hold_v && out_valid) begin
        check("hold_ch", out_ch, hold_ch);
        check("hold_phase", out_phase, hold_ph);
      end
      if (out_valid && out_ready && sb_on) begin
        foreach (exp_q[k]) if (idx < 0 && exp_q[k].ch == out_ch) idx = k;
        if (idx < 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got ch %0d phase %0d expected no beat", out_ch, out_phase);
        end else begin
          check("phase", out_phase, exp_q[idx].ph);
          exp_q.delete(idx);
        end
        if (ord_q.size() > 0) begin
          check("rr_order", out_ch, ord_q[0]);
          void'(ord_q.pop_front());
        end
      end
      hold_v  = out_valid & ~out_ready;
      hold_ch = out_ch;
      hold_ph = out_phase;
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    int p;
    int offs [NC];
    logic [NC-1:0] c;
    foreach (m_last[i]) m_last[i] = 0;

    // Reset with toggling inputs
    for (int t = 0; t < 8; t++) step(t[0], 4'(t));
    check("rst_valid", out_valid, 0);
    check("rst_ch", out_ch, 0);
    check("rst_phase", out_phase, 0);
    check("rst_period", ref_period, 0);
    check("rst_overrun", overrun, 0);
    check("rst_xor", xor_out, 0);
    step(1'b0, '0);
    rst_n = 1'b1;
    repeat (SD + 2) step(1'b0, '0);

    // xor_out follows the inputs SYNC_DEPTH cycles later
    step(1'b1, '0);
    repeat (SD - 1) step(1'b1, '0);
    check("xor_early", xor_out, 4'b0000);
    step(1'b1, '0);
    check("xor_ref", xor_out, 4'b1111);
    step(1'b1, 4'b0101);
    repeat (SD) step(1'b1, 4'b0101);
    check("xor_mix", xor_out, 4'b1010);
    repeat (10) step(1'b0, '0);

    // All channels together, consumer stalled: round-robin delivery in channel order
    set_en(1'b1);
    rdy_fix = 1'b0;
    for (int i = 0; i < NC; i++) ord_q.push_back(i);
    step(1'b1, '0);
    repeat (19) step(1'b1, '0);
    step(1'b1, 4'hF);
    repeat (20) step(1'b1, 4'hF);
    rdy_fix = 1'b1;
    repeat (12) step(1'b0, '0);
    check("rr_overrun", overrun, 0);
    check("rr_drained", exp_q.size() + ord_q.size(), 0);

    // Single 37-cycle phase on ch0
    set_en(1'b0);
    set_en(1'b1);
    step(1'b1, '0);
    repeat (36) step(1'b1, '0);
    step(1'b1, 4'b0001);
    repeat (12) step(1'b0, '0);
    check("p37_drained", exp_q.size(), 0);

    // Reference period of 1000 cycles
    set_en(1'b0);
    set_en(1'b1);
    for (int q = 0; q < 3; q++) begin
      for (int t = 0; t < 1000; t++) begin
        step(t < 500, '0);
        if (t == SD + 4 && q == 0) check("period_first", ref_period, 0);
        if (t == SD + 4 && q == 1) check("period_1000", ref_period, 1000);
      end
    end
    check("period_model", ref_period, m_period);

    // Out-of-range distance saturates
    set_en(1'b0);
    set_en(1'b1);
    step(1'b1, '0);
    for (int t = 1; t < 1200; t++) step(t < 600, '0);
    step(1'b0, 4'b0100);
    repeat (12) step(1'b0, '0);
    check("sat_drained", exp_q.size(), 0);

    // Overwrite of a pending ch1 result while the output holds ch0
    set_en(1'b0);
    set_en(1'b1);
    sb_on = 1'b0;
    rdy_fix = 1'b0;
    step(1'b1, '0);
    repeat (4) step(1'b1, '0);
    step(1'b1, 4'b0001);
    repeat (4) step(1'b1, 4'b0001);
    step(1'b1, 4'b0011);
    repeat (5) step(1'b1, 4'b0011);
    repeat (4) step(1'b0, '0);
    step(1'b1, '0);
    repeat (6) step(1'b1, '0);
    step(1'b1, 4'b0010);
    repeat (SD + 6) step(1'b1, 4'b0010);
    check("ovr_set", overrun, 4'b0010);
    check("ovr_hold_ch", out_ch, 0);
    check("ovr_hold_phase", out_phase, 5);
    rdy_fix = 1'b1;
    step(1'b0, '0);
    rdy_fix = 1'b0;
    step(1'b0, '0);
    check("ovr_next_valid", out_valid, 1);
    check("ovr_next_ch", out_ch, 1);
    check("ovr_next_phase", out_phase, m_last[1]);
    check("ovr_next_7", out_phase, 7);
    set_en(1'b0);
    check("ovr_cleared", overrun, 0);
    check("ovr_out_kept", out_valid, 1);
    rdy_fix = 1'b1;
    repeat (4) step(1'b0, '0);
    check("ovr_out_taken", out_valid, 0);
    sb_on = 1'b1;

    // Randomised beats with a randomly stalling consumer
    set_en(1'b1);
    rdy_rand = 1'b1;
    repeat (5) step(1'b0, 4'hF);
    repeat (5) step(1'b0, '0);
    for (int n = 0; n < 30; n++) begin
      p = $urandom_range(120, 60);
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(7))
          0: offs[i] = -1;
          1: offs[i] = 0;
          default: offs[i] = $urandom_range(3 * p / 4, p / 4);
        endcase
      end
      for (int t = 0; t < p; t++) begin
        c = '0;
        for (int i = 0; i < NC; i++) c[i] = (offs[i] >= 0) && (t >= offs[i]) && (t < offs[i] + 6);
        step(t < p / 2, c);
      end
    end
    repeat (20) step(1'b0, '0);
    rdy_rand = 1'b0;
    rdy_fix = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) step(1'b0, '0);
    check("rand_drained", exp_q.size(), 0);
    check("rand_overrun", overrun, 0);
    check("rand_period", ref_period, m_period);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
